design_chan_rr_sched: RTL and testbench

- Round-robin scheduler that shares one WIDTH-bit datapath input among CHANNEL requesters.
- Each requester presents a word burst. The scheduler grants one channel at a time and forwards its beats through a single-entry registered output stage with valid/ready.
- Sits directly in front of the design's `in` port, sized to match it: WIDTH=32, CHANNEL=50.

---
 rtl/design_sched_pkg.sv | 23 ++
 rtl/design_rr_pick.sv | 27 ++
 rtl/design_chan_rr_sched.sv | 130 +++++++++++++
 tb/tb_design_chan_rr_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_sched_pkg.sv
// Shared types and constants for the round-robin channel scheduler.
package design_sched_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefChannel  = 50;
  localparam int unsigned DefMaxBurst = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } sched_state_e;

  // Ceiling log2, floored at 1 so a single-entry range still gets a 1-bit field.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/design_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr_i, wrapping.
module design_rr_pick #(
  parameter int unsigned CHANNEL = 50,
  parameter int unsigned IDX_W   = 6
) (
  input  logic [CHANNEL-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int pos;
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = CHANNEL - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= int'(CHANNEL)) pos = pos - int'(CHANNEL);
      if (req_i[pos]) begin
        idx_o   = IDX_W'(pos);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/design_chan_rr_sched.sv
// Round-robin scheduler sharing one datapath among CHANNEL burst requesters.
module design_chan_rr_sched
  import design_sched_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CHANNEL   = DefChannel,
  parameter int unsigned MAX_BURST = DefMaxBurst,
  localparam int unsigned IDX_W    = clog2(CHANNEL)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [CHANNEL-1:0]       req_i,
  input  logic [CHANNEL*WIDTH-1:0] req_data_i,
  input  logic [CHANNEL-1:0]       req_last_i,
  output logic [CHANNEL-1:0]       gnt_o,
  output logic                     out_valid_o,
  output logic [WIDTH-1:0]         out_data_o,
  output logic [IDX_W-1:0]         out_chan_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);

  localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_chan_q, out_chan_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             req_own, can_load, accept, rel;
  logic [WIDTH-1:0] own_data;
  logic [IDX_W-1:0] ptr_next;

  design_rr_pick #(
    .CHANNEL (CHANNEL),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Owner-side view of the request bus and the grant/accept decision.
  always_comb begin
    req_own  = req_i[owner_q];
    own_data = req_data_i[int'(owner_q) * WIDTH +: WIDTH];
    can_load = !out_valid_q || out_ready_i;
    accept   = (state_q == StGrant) && req_own && can_load;
    gnt_o    = accept ? (CHANNEL'(1) << owner_q) : '0;
    ptr_next = (owner_q == IDX_W'(CHANNEL - 1)) ? '0 : owner_q + 1'b1;
    busy_o   = (state_q == StGrant);
  end

  // Arbitration FSM: pick in IDLE, stream beats in GRANT until last/cap/abandon.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (!req_own) begin
          rel = 1'b1;
        end else if (can_load) begin
          cnt_d = cnt_q + 1'b1;
          if (req_last_i[owner_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) rel = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rel) begin
      state_d = StIdle;
      ptr_d   = ptr_next;
    end
  end

  // Single-entry output register; a same-cycle drain and load keeps it full.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = own_data;
      out_chan_d  = owner_q;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_design_chan_rr_sched.sv
// Self-checking bench for the round-robin channel scheduler.
module tb_design_chan_rr_sched;

  localparam int CH = 50;
  localparam int W  = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   req, req_last, gnt;
  logic [CH*W-1:0] req_data;
  logic            out_valid, out_ready, busy;
  logic [W-1:0]    out_data;
  logic [5:0]      out_chan;

  int total = 0;
  int bad   = 0;

  logic [5:0]   cap_chan[$];
  logic [W-1:0] cap_data[$];

  typedef struct {
    logic [CH-1:0] req;
    logic [CH-1:0] last;
    logic          rdy;
    logic [CH-1:0] gnt;
    logic          valid;
    logic [5:0]    chan;
    logic          busy;
  } vec_t;

  vec_t tv[18];

  // Random-phase packet store and expected output stream.
  int unsigned  len[CH];
  int unsigned  sent[CH];
  logic [W-1:0] pd[CH][8];
  logic [5:0]   exp_c[$];
  logic [W-1:0] exp_d[$];

  design_chan_rr_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .gnt_o       (gnt),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_chan_o  (out_chan),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [CH-1:0] b(input int i);
    logic [CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] word(input int ch);
    if (ch == 5) return 32'habcdefab;
    return {16'hC0DE, 8'h00, 8'(ch)};
  endfunction

  function automatic vec_t mk(input logic [CH-1:0] r, input logic [CH-1:0] l, input logic rdy,
                              input logic [CH-1:0] g, input logic v, input int c,
                              input logic bs);
    vec_t t;
    t.req = r; t.last = l; t.rdy = rdy; t.gnt = g; t.valid = v; t.chan = 6'(c); t.busy = bs;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, settle, and capture any output transfer.
  task automatic drive(input logic [CH-1:0] r, input logic [CH-1:0] l, input logic rdy,
                       input int och, input logic [W-1:0] od);
    @(negedge clk);
    req       = r;
    req_last  = l;
    out_ready = rdy;
    for (int i = 0; i < CH; i++) req_data[i*W +: W] = (i == och) ? od : word(i);
    #1;
    if (out_valid && out_ready) begin
      cap_chan.push_back(out_chan);
      cap_data.push_back(out_data);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = '0;
    req_last  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_chan.delete();
    cap_data.delete();
  endtask

  // Expected output order from the round-robin rules applied to whole packets.
  task automatic build_model();
    int unsigned rem[CH];
    int unsigned pos[CH];
    int p, left, n;
    p    = 0;
    left = 0;
    exp_c.delete();
    exp_d.delete();
    for (int c = 0; c < CH; c++) begin
      rem[c] = len[c];
      pos[c] = 0;
      left  += int'(len[c]);
    end
    while (left > 0) begin
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (p + k) % CH;
        if (rem[c] > 0) begin
          n = (rem[c] > MB) ? MB : int'(rem[c]);
          for (int j = 0; j < n; j++) begin
            exp_c.push_back(6'(c));
            exp_d.push_back(pd[c][pos[c]]);
            pos[c]++;
          end
          rem[c] -= n;
          left   -= n;
          p       = (c + 1) % CH;
          break;
        end
      end
    end
  endtask

  initial begin
    int nb;
    int cnt;
    logic [CH-1:0] gexp;
    logic [CH-1:0] r3;

    // Reset held with every channel requesting.
    rst_n     = 1'b0;
    req       = '1;
    req_last  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < CH; i++) req_data[i*W +: W] = word(i);
    #12;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_idle_gnt", 64'(gnt), 64'(0));
    @(negedge clk);
    #1;
    chk("first_gnt_ch0", 64'(gnt), 64'(b(0)));
    chk("first_busy", 64'(busy), 64'(1));

    // Table: single channel burst, then a wrap-around round-robin sequence.
    r3 = b(48) | b(49) | b(2);
    tv[0]  = mk(b(5), '0, 1'b1, '0, 1'b0, 0, 1'b0);
    tv[1]  = mk(b(5), '0, 1'b1, b(5), 1'b0, 0, 1'b1);
    tv[2]  = mk(b(5), '0, 1'b1, b(5), 1'b1, 5, 1'b1);
    tv[3]  = mk(b(5), b(5), 1'b1, b(5), 1'b1, 5, 1'b1);
    tv[4]  = mk('0, '0, 1'b1, '0, 1'b1, 5, 1'b0);
    tv[5]  = mk('0, '0, 1'b1, '0, 1'b0, 0, 1'b0);
    tv[6]  = mk(b(47), b(47), 1'b1, '0, 1'b0, 0, 1'b0);
    tv[7]  = mk(b(47), b(47), 1'b1, b(47), 1'b0, 0, 1'b1);
    tv[8]  = mk(r3, '1, 1'b1, '0, 1'b1, 47, 1'b0);
    tv[9]  = mk(r3, '1, 1'b1, b(48), 1'b0, 0, 1'b1);
    tv[10] = mk(b(49) | b(2), '1, 1'b1, '0, 1'b1, 48, 1'b0);
    tv[11] = mk(b(49) | b(2), '1, 1'b1, b(49), 1'b0, 0, 1'b1);
    tv[12] = mk(b(2), '1, 1'b1, '0, 1'b1, 49, 1'b0);
    tv[13] = mk(b(2), '1, 1'b1, b(2), 1'b0, 0, 1'b1);
    tv[14] = mk('0, '0, 1'b1, '0, 1'b1, 2, 1'b0);
    tv[15] = mk(b(2) | b(3), '1, 1'b1, '0, 1'b0, 0, 1'b0);
    tv[16] = mk(b(2) | b(3), '1, 1'b1, b(3), 1'b0, 0, 1'b1);
    tv[17] = mk('0, '0, 1'b1, '0, 1'b1, 3, 1'b0);
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].req, tv[i].last, tv[i].rdy, -1, '0);
      chk($sformatf("tv%0d_gnt", i), 64'(gnt), 64'(tv[i].gnt));
      chk($sformatf("tv%0d_valid", i), 64'(out_valid), 64'(tv[i].valid));
      chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].busy));
      if (tv[i].valid) begin
        chk($sformatf("tv%0d_chan", i), 64'(out_chan), 64'(tv[i].chan));
        chk($sformatf("tv%0d_data", i), 64'(out_data), 64'(word(int'(tv[i].chan))));
      end
    end
    chk("tv_word_count", 64'(cap_chan.size()), 64'(8));

    // Burst cap: 4 beats, one dead cycle, then re-grant to the same channel.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(b(7), '0, 1'b1, 7, 32'h12345678);
      gexp = (k == 0 || k == 5) ? '0 : b(7);
      chk($sformatf("cap_gnt%0d", k), 64'(gnt), 64'(gexp));
      if (k == 5) chk("cap_dead_busy", 64'(busy), 64'(0));
    end

    // Backpressure mid-burst: held word must stay put, no beat lost or repeated.
    do_reset();
    nb = 0;
    for (int k = 0; k < 14; k++) begin
      drive((nb < 4) ? b(9) : '0, (nb == 3) ? b(9) : '0, !(k >= 3 && k <= 7), 9,
            32'haaaaaaa9 + 32'(nb));
      if (k >= 3 && k <= 7) begin
        chk($sformatf("bp_gnt%0d", k), 64'(gnt), 64'(0));
        chk($sformatf("bp_hold%0d", k), 64'({out_valid, out_data}), {31'd0, 1'b1, 32'haaaaaaaa});
      end
      if (gnt[9] && req[9]) nb++;
    end
    chk("bp_count", 64'(cap_data.size()), 64'(4));
    for (int j = 0; j < 4 && j < cap_data.size(); j++) begin
      chk($sformatf("bp_word%0d", j), 64'({cap_chan[j], cap_data[j]}),
          64'({6'd9, 32'haaaaaaa9 + 32'(j)}));
    end

    // Abandon after two beats: release and advance the pointer past the owner.
    do_reset();
    for (int k = 0; k < 3; k++) drive(b(11), '0, 1'b1, -1, '0);
    chk("ab_gnt_beat2", 64'(gnt), 64'(b(11)));
    drive('0, '0, 1'b1, -1, '0);
    chk("ab_drop_gnt", 64'(gnt), 64'(0));
    drive(b(10) | b(11) | b(12), '0, 1'b1, -1, '0);
    chk("ab_idle_busy", 64'(busy), 64'(0));
    drive(b(10) | b(11) | b(12), '0, 1'b1, -1, '0);
    chk("ab_next_owner", 64'(gnt), 64'(b(12)));

    // Asynchronous reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 3; k++) drive(b(13), '0, 1'b1, -1, '0);
    chk("mr_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_data", 64'(out_data), 64'(0));
    chk("mr_chan", 64'(out_chan), 64'(0));
    chk("mr_gnt", 64'(gnt), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized packets against the packet-level round-robin model.
    for (int rnd = 0; rnd < 3; rnd++) begin
      do_reset();
      for (int c = 0; c < CH; c++) begin
        len[c]  = 0;
        sent[c] = 0;
      end
      for (int j = 0; j < 10; j++) begin
        int c;
        c      = int'($urandom_range(0, CH - 1));
        len[c] = $urandom_range(1, 7);
        for (int k = 0; k < 8; k++) pd[c][k] = $urandom;
      end
      build_model();
      cnt = 0;
      while (cnt < 1500 && exp_c.size() > 0) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < CH; c++) begin
          req[c]             = (sent[c] < len[c]);
          req_last[c]        = (sent[c] < len[c]) && (sent[c] + 1 == len[c]);
          req_data[c*W +: W] = (sent[c] < 8) ? pd[c][sent[c]] : '0;
        end
        #1;
        chk("rnd_gnt_legal", 64'(((gnt & (gnt - 1'b1)) == '0) && ((gnt & ~req) == '0)), 64'(1));
        if (out_valid && out_ready) begin
          if (exp_c.size() > 0) begin
            chk("rnd_out", 64'({out_chan, out_data}), 64'({exp_c[0], exp_d[0]}));
            void'(exp_c.pop_front());
            void'(exp_d.pop_front());
          end
        end
        for (int c = 0; c < CH; c++) if (gnt[c] && req[c]) sent[c]++;
        cnt++;
      end
      chk($sformatf("rnd%0d_drain", rnd), 64'(exp_c.size()), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
